// File: rtl/wb_host_pkg.sv
// Shared types and default widths for the Wishbone host initiator.
package wb_host_pkg;

    localparam int WB_ADDR_W  = 32;
    localparam int WB_DATA_W  = 32;
    localparam int WB_SEL_W   = WB_DATA_W / 8;
    localparam int WB_TIMEOUT = 255;
    localparam int WB_TO_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles after a clear and flags when the
// count reaches TIMEOUT.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer master: turns valid/ready commands into
// bus cycles and returns one response per command, aborting on a missing ack.
module wb_host_initiator
    import wb_host_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = WB_TIMEOUT,
    parameter int TO_W    = WB_TO_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i
);

    wb_state_e         state_q, state_d;
    wb_cmd_t           cmd_q;
    logic              ready_en_q;
    logic              cyc_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_dat_q;

    logic accept, ack_done, timed_out, rsp_done;
    logic ctr_clear, ctr_en, ctr_expired;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (ctr_expired)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    // Ack is checked before the timeout so an ack on the final cycle still counts.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        accept      = 1'b0;
        ack_done    = 1'b0;
        timed_out   = 1'b0;
        rsp_done    = 1'b0;
        ctr_clear   = 1'b0;
        ctr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = ready_en_q;
                if (cmd_valid_i && ready_en_q) begin
                    accept    = 1'b1;
                    ctr_clear = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    ack_done = 1'b1;
                    state_d  = RESP;
                end else if (ctr_expired) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cmd_q       <= '0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            if (accept) begin
                cmd_q <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i};
                cyc_q <= 1'b1;
            end
            if (ack_done || timed_out) begin
                cyc_q       <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= timed_out;
                rsp_dat_q   <= (ack_done && !cmd_q.we) ? wbm_dat_i : '0;
            end
            if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = cmd_q.we;
    assign wbm_adr_o   = cmd_q.adr;
    assign wbm_dat_o   = cmd_q.dat;
    assign wbm_sel_o   = cmd_q.sel;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed self-checking bench for wb_host_initiator with TIMEOUT=4; the
// Wishbone slave is played by hand from the stimulus sequence.
module tb_wb_host_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack;

    int errors = 0;
    int checks = 0;

    wb_host_initiator #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [31:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack   = 1'b0;

        // Reset state
        tick();
        tick();
        check_output("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_output("rst_cyc", 32'(wbm_cyc), 32'd0);
        check_output("rst_stb", 32'(wbm_stb), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_adr", wbm_adr, 32'd0);
        check_output("rst_rsp_dat", rsp_dat, 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("ready_before_edge", 32'(cmd_ready), 32'd0);
        tick();
        check_output("ready_after_edge", 32'(cmd_ready), 32'd1);

        // Write, zero-wait slave
        apply_stimulus(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check_output("wr_cyc", 32'(wbm_cyc), 32'd1);
        check_output("wr_stb", 32'(wbm_stb), 32'd1);
        check_output("wr_we", 32'(wbm_we), 32'd1);
        check_output("wr_adr", wbm_adr, 32'h3000_0004);
        check_output("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
        check_output("wr_sel", 32'(wbm_sel), 32'hF);
        check_output("wr_busy_ready", 32'(cmd_ready), 32'd0);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check_output("wr_stb_drop", 32'(wbm_stb), 32'd0);
        check_output("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("wr_rsp_err", 32'(rsp_err), 32'd0);
        check_output("wr_rsp_dat", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("wr_rsp_done", 32'(rsp_valid), 32'd0);
        check_output("wr_idle_ready", 32'(cmd_ready), 32'd1);

        // Read with three wait states
        apply_stimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("rd_wait_stb%0d", i), 32'(wbm_stb), 32'd1);
            check_output($sformatf("rd_wait_ready%0d", i), 32'(cmd_ready), 32'd0);
            tick();
        end
        check_output("rd_stb_last", 32'(wbm_stb), 32'd1);
        check_output("rd_we", 32'(wbm_we), 32'd0);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack   = 1'b0;
        wbm_dat_i = 32'hFFFF_0000;
        check_output("rd_stb_drop", 32'(wbm_stb), 32'd0);
        check_output("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        check_output("rd_rsp_err", 32'(rsp_err), 32'd0);

        // Backpressure with a pending command that must not start a bus cycle
        apply_stimulus(1'b1, 32'h3000_0010, 32'h0000_0011, 4'h1);
        for (int i = 0; i < 10; i++) begin
            check_output($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            check_output($sformatf("bp_dat%0d", i), rsp_dat, 32'h1234_5678);
            check_output($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'd0);
            check_output($sformatf("bp_cyc%0d", i), 32'(wbm_cyc), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check_output("bp_release_valid", 32'(rsp_valid), 32'd0);
        check_output("bp_release_ready", 32'(cmd_ready), 32'd1);
        check_output("bp_release_cyc", 32'(wbm_cyc), 32'd0);

        // Back-to-back commands, rsp_ready held high: A then B (sel=0 forwarded)
        tick();
        check_output("b2b_a_cyc", 32'(wbm_cyc), 32'd1);
        check_output("b2b_a_adr", wbm_adr, 32'h3000_0010);
        check_output("b2b_a_dat", wbm_dat_o, 32'h0000_0011);
        apply_stimulus(1'b1, 32'h3000_0015, 32'h0000_0022, 4'h0);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check_output("b2b_a_rsp", 32'(rsp_valid), 32'd1);
        check_output("b2b_a_ready", 32'(cmd_ready), 32'd0);
        tick();
        check_output("b2b_a_done", 32'(rsp_valid), 32'd0);
        check_output("b2b_b_not_yet", 32'(wbm_cyc), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check_output("b2b_b_cyc", 32'(wbm_cyc), 32'd1);
        check_output("b2b_b_adr", wbm_adr, 32'h3000_0015);
        check_output("b2b_b_dat", wbm_dat_o, 32'h0000_0022);
        check_output("b2b_b_sel", 32'(wbm_sel), 32'h0);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check_output("b2b_b_rsp", 32'(rsp_valid), 32'd1);
        tick();
        rsp_ready = 1'b0;
        check_output("b2b_b_done", 32'(rsp_valid), 32'd0);

        // Timeout: slave never acks
        wbm_dat_i = 32'hAAAA_AAAA;
        apply_stimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("to_stb%0d", i), 32'(wbm_stb), 32'd1);
            tick();
        end
        check_output("to_stb_drop", 32'(wbm_stb), 32'd0);
        check_output("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check_output("to_rsp_err", 32'(rsp_err), 32'd1);
        check_output("to_rsp_dat", rsp_dat, 32'd0);
        tick();
        tick();
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check_output("late_ack_valid", 32'(rsp_valid), 32'd1);
        check_output("late_ack_err", 32'(rsp_err), 32'd1);
        check_output("late_ack_cyc", 32'(wbm_cyc), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("to_done", 32'(rsp_valid), 32'd0);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check_output("idle_ack_cyc", 32'(wbm_cyc), 32'd0);
        check_output("idle_ack_valid", 32'(rsp_valid), 32'd0);

        // Normal read after a timeout
        apply_stimulus(1'b0, 32'h3000_0024, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check_output("post_to_stb", 32'(wbm_stb), 32'd1);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'h5555_0001;
        tick();
        wbm_ack = 1'b0;
        check_output("post_to_dat", rsp_dat, 32'h5555_0001);
        check_output("post_to_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Ack arriving on the timeout cycle
        apply_stimulus(1'b0, 32'h3000_0028, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_output("edge_stb", 32'(wbm_stb), 32'd1);
        wbm_ack   = 1'b1;
        wbm_dat_i = 32'hCAFE_F00D;
        tick();
        wbm_ack = 1'b0;
        check_output("edge_valid", 32'(rsp_valid), 32'd1);
        check_output("edge_err", 32'(rsp_err), 32'd0);
        check_output("edge_dat", rsp_dat, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset asserted in the middle of a bus cycle
        apply_stimulus(1'b1, 32'h3000_0030, 32'h0000_00AA, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check_output("mid_rst_stb_before", 32'(wbm_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_cyc", 32'(wbm_cyc), 32'd0);
        check_output("mid_rst_stb", 32'(wbm_stb), 32'd0);
        check_output("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_output("mid_rst_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_output("post_rst_ready", 32'(cmd_ready), 32'd1);
        apply_stimulus(1'b1, 32'h3000_0000, 32'h0000_0001, 4'h3);
        tick();
        cmd_valid = 1'b0;
        check_output("post_rst_adr", wbm_adr, 32'h3000_0000);
        check_output("post_rst_sel", 32'(wbm_sel), 32'h3);
        wbm_ack = 1'b1;
        tick();
        wbm_ack = 1'b0;
        check_output("post_rst_valid", 32'(rsp_valid), 32'd1);
        check_output("post_rst_err", 32'(rsp_err), 32'd0);
        check_output("post_rst_dat", rsp_dat, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_host_initiator.md
Name: wb_host_initiator

Overview:
- Wishbone classic (B3, single-transfer) master. Converts a simple valid/ready command stream into bus cycles towards the user-area Wishbone slave.
- Slave side: SRAM loader and processor-reset control.
- Used by the on-chip debug/loader path and by the verification environment to write the instruction SRAM, release processor reset and read back status.
- Adds a bus-cycle timeout so a missing ack never hangs the host.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; SEL_W = DATA_W/8.
- TIMEOUT, 255, cycles to wait for ack before aborting; must be >= 1.
- TO_W, 8, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- wb_clk_i  in  1  single clock, all logic rising-edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  ADDR_W  byte address.
- cmd_dat_i  in  DATA_W  write data.
- cmd_sel_i  in  SEL_W  byte enables.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  DATA_W  read data (0 for writes and timeouts).
- rsp_err_o  out  1  1 = cycle aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  SEL_W  byte select.
- wbm_adr_o  out  ADDR_W  address.
- wbm_dat_o  out  DATA_W  write data.
- wbm_dat_i  in  DATA_W  read data.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset (async assert, sync deassert, external synchronizer):
  - State IDLE.
  - cmd_ready_o=0 during reset, 1 from the first clock after deassert.
  - rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0.
  - wbm_cyc_o=wbm_stb_o=wbm_we_o=0; wbm_sel_o, wbm_adr_o, wbm_dat_o all 0.
  - Timeout counter 0.
- FSM IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: register we/adr/dat/sel into the wbm_* outputs, assert cyc=stb=1 the next cycle, clear the counter, go to BUS.
- BUS:
  - cmd_ready_o=0; cyc/stb held and all wbm_* outputs stable.
  - If wbm_ack_i is sampled high:
    - Deassert cyc/stb the next cycle.
    - Capture wbm_dat_i into rsp_dat_o on reads, or set rsp_dat_o=0 on writes.
    - rsp_err_o=0, rsp_valid_o=1, go to RESP.
  - Else if counter==TIMEOUT: deassert cyc/stb, rsp_err_o=1, rsp_dat_o=0, rsp_valid_o=1, go to RESP.
  - Else counter+1.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP:
  - rsp_valid_o held with dat/err stable until rsp_ready_i.
  - On handshake: rsp_valid_o=0, go to IDLE.
  - Next command may be accepted no earlier than the cycle after the response handshake (cmd_ready_o=0 in RESP).
- Latency:
  - cmd handshake at cycle N -> stb high at N+1.
  - Zero-wait slave (ack at N+1) -> rsp_valid_o at N+2.
  - Minimum 3-cycle issue interval with rsp_ready_i tied 1.
- wbm_ack_i outside BUS is ignored (spurious/late ack after timeout is discarded).
- cmd_sel_i=0 is forwarded unchanged; no address alignment check, adr passed verbatim.
- Reset asserted mid-cycle: cyc/stb drop immediately (async), any pending response is lost.

Decomposition:
- Package wb_host_pkg:
  - state enum (IDLE, BUS, RESP).
  - Default width constants.
  - A struct for the registered command {we, adr, dat, sel}.
- Sub-module wb_timeout_ctr: clear/enable inputs, expired output at count==TIMEOUT. Reusable by future Wishbone masters.
- Everything else is in the single FSM module.

Test Plan:
- Write, zero-wait slave: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, ack the cycle after stb -> one cyc/stb pulse with those values, rsp_valid=1 two cycles after accept, rsp_err=0, rsp_dat=0.
- Read, 3 wait states: slave returns 0x1234_5678 -> stb held 4 cycles, rsp_dat=0x1234_5678, cmd_ready=0 throughout until response consumed.
- Timeout: TIMEOUT=4, slave never acks -> cyc/stb drop after 5 cycles, rsp_err=1, rsp_dat=0. A late ack 2 cycles later is ignored; the next command is issued normally.
- Backpressure: rsp_ready=0 for 10 cycles after a read -> rsp_valid/rsp_dat stable, cmd_ready=0, no new bus cycle. Releasing rsp_ready returns to IDLE, then back-to-back commands complete in order.
- Ack on the timeout cycle: ack asserted exactly when counter==TIMEOUT -> rsp_err=0, data captured.
- Reset mid-BUS: pull wb_rst_n_i low while stb=1 -> cyc/stb/rsp_valid=0 asynchronously; after release, cmd_ready=1 and a fresh write completes.
